bus_responder: RTL and testbench

Memory-mapped target on the cpu6502 external bus, the responding end of the bus that the cpu6502 core initiates. It decodes the CPU address and read/write strobe into three targets: on-chip RAM, a byte output port with an 8-entry FIFO, and fixed reset/IRQ/NMI vectors. It drives read data back to the core and presents FIFO contents on a valid/ready stream for a host or serial transmitter.

---
 rtl/bus_map_pkg.sv | 52 +++++
 rtl/byte_fifo.sv | 59 +++++
 rtl/bus_responder.sv | 104 ++++++++++
 tb/tb_bus_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_map_pkg.sv
// Address map, STATUS layout and decode helpers shared by the bus responder.
package bus_map_pkg;

   typedef enum logic [2:0] {
      TGT_RAM,
      TGT_DATA,
      TGT_STATUS,
      TGT_VEC,
      TGT_NONE
   } tgt_e;

   localparam logic [15:0] IO_DATA_OFS   = 16'd0;
   localparam logic [15:0] IO_STATUS_OFS = 16'd1;
   localparam logic [15:0] VEC_NMI_LO    = 16'hFFFA;
   localparam logic [15:0] VEC_RST_LO    = 16'hFFFC;
   localparam logic [15:0] VEC_IRQ_LO    = 16'hFFFE;

   localparam int ST_FULL    = 0;
   localparam int ST_EMPTY   = 1;
   localparam int ST_OVF     = 2;
   localparam int ST_CNT_LSB = 4;

   localparam logic [7:0] UNMAPPED_RD = 8'hFF;

   function automatic logic [16:0] ram_limit(input int ram_aw);
      return 17'(1) << ram_aw;
   endfunction

   function automatic tgt_e decode(input logic [15:0] a, input int ram_aw,
                                   input logic [15:0] io_base);
      if ({1'b0, a} < ram_limit(ram_aw))
         return TGT_RAM;
      else if (a == io_base + IO_DATA_OFS)
         return TGT_DATA;
      else if (a == io_base + IO_STATUS_OFS)
         return TGT_STATUS;
      else if (a >= VEC_NMI_LO)
         return TGT_VEC;
      else
         return TGT_NONE;
   endfunction

   // NMI shares the IRQ vector; only $FFFC/$FFFD select the reset vector.
   function automatic logic [7:0] vec_byte(input logic [15:0] a,
                                           input logic [15:0] reset_vec,
                                           input logic [15:0] irq_vec);
      logic [15:0] v;
      v = (a[15:1] == VEC_RST_LO[15:1]) ? reset_vec : irq_vec;
      return a[0] ? v[15:8] : v[7:0];
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// 8-deep byte FIFO with registered storage; a pop in the same cycle frees a slot for a push.
module byte_fifo #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop_req,
   output logic [W-1:0] head,
   output logic         valid,
   output logic [3:0]   count,
   output logic         full,
   output logic         empty,
   output logic         drop
);

   logic [W-1:0] mem_q [8];
   logic [W-1:0] mem_d [8];
   logic [2:0]   wr_ptr_q, wr_ptr_d;
   logic [2:0]   rd_ptr_q, rd_ptr_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         pop_ok;
   logic         push_ok;

   assign empty = (cnt_q == 4'd0);
   assign full  = (cnt_q == 4'd8);
   assign valid = ~empty;
   assign head  = mem_q[rd_ptr_q];
   assign count = cnt_q;

   always_comb begin
      mem_d    = mem_q;
      pop_ok   = pop_req & ~empty;
      push_ok  = push & (~full | pop_ok);
      drop     = push & full & ~pop_ok;
      if (push_ok)
         mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = wr_ptr_q + 3'(push_ok);
      rd_ptr_d = rd_ptr_q + 3'(pop_ok);
      cnt_d    = cnt_q + 4'(push_ok) - 4'(pop_ok);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < 8; i++)
            mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/bus_responder.sv
// cpu6502 bus target: RAM, byte output FIFO with STATUS, fixed vectors, registered read data.
module bus_responder
   import bus_map_pkg::*;
#(
   parameter int          RAM_AW    = 11,
   parameter logic [15:0] IO_BASE   = 16'hD000,
   parameter logic [15:0] RESET_VEC = 16'h0000,
   parameter logic [15:0] IRQ_VEC   = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   input  logic        rw,
   input  logic        clk2,
   output logic [7:0]  rdata,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready
);

   logic [7:0] ram_mem [1 << RAM_AW];

   logic       clk2_q, clk2_d;
   logic       ovf_q, ovf_d;
   logic [7:0] rdata_q, rdata_d;
   tgt_e       tgt;
   logic       w_evt;
   logic       data_push;
   logic [7:0] fifo_head;
   logic       fifo_valid;
   logic [3:0] fifo_count;
   logic       fifo_full;
   logic       fifo_empty;
   logic       fifo_drop;
   logic [7:0] status;

   assign tgt       = decode(addr, RAM_AW, IO_BASE);
   // One commit per bus cycle: only the first clk cycle after phi2 rises.
   assign w_evt     = clk2 & ~clk2_q & ~rw;
   assign data_push = w_evt & (tgt == TGT_DATA);

   byte_fifo #(.W(8)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (data_push),
      .push_data (wdata),
      .pop_req   (out_ready),
      .head      (fifo_head),
      .valid     (fifo_valid),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .drop      (fifo_drop)
   );

   always_comb begin
      status                    = '0;
      status[ST_FULL]           = fifo_full;
      status[ST_EMPTY]          = fifo_empty;
      status[ST_OVF]            = ovf_q;
      status[ST_CNT_LSB +: 4]   = fifo_count;
   end

   always_comb begin
      clk2_d  = clk2;
      ovf_d   = ovf_q;
      rdata_d = UNMAPPED_RD;
      if (w_evt && (tgt == TGT_STATUS))
         ovf_d = 1'b0;
      if (fifo_drop)
         ovf_d = 1'b1;
      case (tgt)
         TGT_RAM:    rdata_d = ram_mem[addr[RAM_AW-1:0]];
         TGT_DATA:   rdata_d = fifo_empty ? UNMAPPED_RD : fifo_head;
         TGT_STATUS: rdata_d = status;
         TGT_VEC:    rdata_d = vec_byte(addr, RESET_VEC, IRQ_VEC);
         default:    rdata_d = UNMAPPED_RD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         clk2_q  <= 1'b0;
         ovf_q   <= 1'b0;
         rdata_q <= UNMAPPED_RD;
      end else begin
         clk2_q  <= clk2_d;
         ovf_q   <= ovf_d;
         rdata_q <= rdata_d;
      end
   end

   // RAM contents survive reset, but a write in a reset cycle is dropped.
   always_ff @(posedge clk) begin
      if (reset && w_evt && (tgt == TGT_RAM))
         ram_mem[addr[RAM_AW-1:0]] <= wdata;
   end

   assign rdata     = rdata_q;
   assign out_data  = fifo_head;
   assign out_valid = fifo_valid;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: queue/array reference model plus directed bus cycles.
module tb_bus_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        rw;
   logic        clk2;
   logic [7:0]  rdata;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bus_responder #(
      .RAM_AW    (11),
      .IO_BASE   (16'hD000),
      .RESET_VEC (16'hC000),
      .IRQ_VEC   (16'hABCD)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .wdata     (wdata),
      .rw        (rw),
      .clk2      (clk2),
      .rdata     (rdata),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: what the bus should look like, tracked at transaction level.
   logic [7:0] m_ram [int];
   logic [7:0] m_q [$];
   bit         m_ovf = 0;
   bit         m_c2p = 0;
   bit         m_started = 0;
   bit         m_in_reset = 0;
   logic [7:0] e_rdata = 8'hFF;
   bit         e_known = 0;
   bit         e_valid = 0;
   logic [7:0] e_head = 8'h00;

   function automatic void mread(input logic [15:0] a, output logic [7:0] v, output bit known);
      known = 1;
      v     = 8'hFF;
      if (a < 16'h0800) begin
         if (m_ram.exists(int'(a))) v = m_ram[int'(a)];
         else known = 0;
      end else if (a == 16'hD000) begin
         v = (m_q.size() != 0) ? m_q[0] : 8'hFF;
      end else if (a == 16'hD001) begin
         v = {4'(m_q.size()), 1'b0, m_ovf, (m_q.size() == 0), (m_q.size() == 8)};
      end else begin
         case (a)
            16'hFFFA: v = 8'hCD;
            16'hFFFB: v = 8'hAB;
            16'hFFFC: v = 8'h00;
            16'hFFFD: v = 8'hC0;
            16'hFFFE: v = 8'hCD;
            16'hFFFF: v = 8'hAB;
            default:  v = 8'hFF;
         endcase
      end
   endfunction

   always @(posedge clk) begin
      bit         wev;
      logic [7:0] v;
      bit         kn;
      m_started = 1;
      if (!reset) begin
         m_q.delete();
         m_ovf      = 0;
         m_c2p      = 0;
         e_rdata    = 8'hFF;
         e_known    = 1;
         m_in_reset = 1;
      end else begin
         m_in_reset = 0;
         mread(addr, v, kn);
         e_rdata = v;
         e_known = kn;
         wev = clk2 && !m_c2p && !rw;
         if (m_q.size() != 0 && out_ready)
            void'(m_q.pop_front());
         if (wev) begin
            if (addr < 16'h0800)
               m_ram[int'(addr)] = wdata;
            else if (addr == 16'hD000) begin
               if (m_q.size() < 8) m_q.push_back(wdata);
               else m_ovf = 1;
            end else if (addr == 16'hD001)
               m_ovf = 0;
         end
         m_c2p = clk2;
      end
      e_valid = (m_q.size() != 0);
      e_head  = e_valid ? m_q[0] : 8'h00;
   end

   always @(negedge clk) begin
      if (m_started) begin
         if (e_known) chk("rdata", rdata, e_rdata);
         chk("out_valid", {7'b0, out_valid}, {7'b0, e_valid});
         if (e_valid || m_in_reset) chk("out_data", out_data, e_head);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [7:0] v);
      tick();
      addr = a;
      rw   = 1'b1;
      clk2 = 1'b0;
      tick();
      v = rdata;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input bit pop_on_edge);
      tick();
      addr  = a;
      wdata = d;
      rw    = 1'b0;
      clk2  = 1'b0;
      tick();
      tick();
      clk2      = 1'b1;
      out_ready = pop_on_edge;
      tick();
      out_ready = 1'b0;
      tick();
      clk2 = 1'b0;
      rw   = 1'b1;
   endtask

   task automatic drain(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         chk("drain_valid", {7'b0, out_valid}, 8'h01);
         chk("drain_data", out_data, first + 8'(i));
         out_ready = 1'b1;
         tick();
      end
      out_ready = 1'b0;
      chk("drain_empty", {7'b0, out_valid}, 8'h00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected end before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] v;
      reset     = 1'b0;
      addr      = 16'h1234;
      wdata     = 8'h00;
      rw        = 1'b1;
      clk2      = 1'b0;
      out_ready = 1'b0;
      repeat (3) tick();
      chk("reset_rdata", rdata, 8'hFF);
      chk("reset_valid", {7'b0, out_valid}, 8'h00);
      chk("reset_out_data", out_data, 8'h00);
      reset = 1'b1;
      repeat (3) tick();
      chk("idle_rdata", rdata, 8'hFF);
      bus_read(16'hD001, v);  chk("status_idle", v, 8'h02);

      bus_write(16'h0099, 8'h55, 0);
      bus_read(16'h0099, v);  chk("ram_rd", v, 8'h55);
      bus_read(16'h1234, v);  chk("unmapped_rd", v, 8'hFF);

      bus_read(16'hFFFC, v);  chk("rst_vec_lo", v, 8'h00);
      bus_read(16'hFFFD, v);  chk("rst_vec_hi", v, 8'hC0);
      bus_write(16'hFFFC, 8'h12, 0);
      bus_read(16'hFFFC, v);  chk("vec_wr_ignored", v, 8'h00);
      bus_read(16'hFFFA, v);  chk("nmi_vec_lo", v, 8'hCD);
      bus_read(16'hFFFF, v);  chk("irq_vec_hi", v, 8'hAB);

      for (int i = 1; i <= 8; i++) bus_write(16'hD000, 8'(i), 0);
      bus_read(16'hD001, v);  chk("status_full", v, 8'h81);
      bus_write(16'hD000, 8'h09, 0);
      bus_read(16'hD001, v);  chk("status_ovf", v, 8'h85);
      bus_read(16'hD000, v);  chk("data_peek", v, 8'h01);
      drain(8'h01, 8);
      bus_read(16'hD000, v);  chk("data_empty", v, 8'hFF);
      bus_read(16'hD001, v);  chk("status_drained", v, 8'h06);
      bus_write(16'hD001, 8'h00, 0);
      bus_read(16'hD001, v);  chk("ovf_cleared", v, 8'h02);

      for (int i = 0; i < 8; i++) bus_write(16'hD000, 8'h11 + 8'(i), 0);
      bus_write(16'hD000, 8'h19, 1);
      bus_read(16'hD001, v);  chk("full_push_pop", v, 8'h81);
      drain(8'h12, 8);
      bus_read(16'hD001, v);  chk("full_push_pop_end", v, 8'h02);

      tick();
      addr  = 16'hD000;
      wdata = 8'h5A;
      rw    = 1'b0;
      clk2  = 1'b0;
      tick();
      tick();
      clk2  = 1'b1;
      reset = 1'b0;
      tick();
      clk2  = 1'b0;
      rw    = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      bus_read(16'hD001, v);  chk("reset_abort", v, 8'h02);
      bus_write(16'hD000, 8'hAA, 0);
      tick();
      chk("resume_valid", {7'b0, out_valid}, 8'h01);
      chk("resume_data", out_data, 8'hAA);
      drain(8'hAA, 1);

      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
